smi_stream_ctrl: RTL and testbench
==================================

SMI_STREAM_CTRL -- requirements
Module: smi_stream_ctrl

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, meaning number of source FIFO channels (1..4).
REQ-002 SHALL have parameter WORD_W, default 32, meaning FIFO word width, a multiple of 8.
REQ-003 SHALL have parameter MODULE_VERSION, default 8'h02, meaning value returned by the version register.
REQ-004 SHALL have one clock; reset is synchronous and active-high.
REQ-005 Port: i_sys_clk  in  1  FPGA system clock; all logic on its rising edge.
REQ-006 Port: i_rst  in  1  synchronous active-high reset.
REQ-007 Port: i_ioc  in  5  register address.
REQ-008 Port: i_data_in  in  8  register write data.
REQ-009 Port: o_data_out  out  8  register read data.
REQ-010 Port: i_cs  in  1  register chip select.
REQ-011 Port: i_fetch_cmd  in  1  register read strobe.
REQ-012 Port: i_load_cmd  in  1  register write strobe.
REQ-013 Port: o_fifo_pull  out  NUM_CH  per-channel FIFO pop, one-cycle pulse.
REQ-014 Port: i_fifo_pulled_data  in  NUM_CH*WORD_W  flattened FIFO words; channel k at [k*WORD_W +: WORD_W].
REQ-015 Port: i_fifo_empty  in  NUM_CH  per-channel empty flag.
REQ-016 Port: i_smi_rd  in  1  single-cycle stream byte request from the SMI side.
REQ-017 Port: o_smi_data  out  8  stream byte.
REQ-018 Port: o_smi_valid  out  1  one-cycle pulse, o_smi_data valid.

Function
REQ-019 Registers: 0x00 VERSION (RO, MODULE_VERSION); 0x01 CHSEL (RW, bits[1:0]); 0x02 CTRL (RW, bit0 EN, bit1 MSB_FIRST); 0x03 STATUS (RO except W1C bit7: bits[NUM_CH-1:0] = i_fifo_empty, bit7 = sticky underrun); 0x04 URCNT (RO, saturating 8-bit underrun count, cleared with the bit7 W1C).
REQ-020 Read: i_cs=1 and i_fetch_cmd=1 -> o_data_out = addressed register at next edge; unmapped address -> 8'h00; i_cs=0 -> o_data_out 8'h00 at next edge; otherwise it holds.
REQ-021 Write: i_cs=1 and i_load_cmd=1 -> addressed RW field updated at next edge; writes to RO/unmapped addresses ignored; CHSEL values >= NUM_CH are clamped to NUM_CH-1.
REQ-022 FSM states: IDLE, PULL, LOAD, SHIFT.
REQ-023 IDLE -> PULL when EN=1 and i_fifo_empty[CHSEL]=0; the channel is latched into an active-channel register at this transition.
REQ-024 PULL: o_fifo_pull[active]=1 for exactly one cycle, all other bits 0; -> LOAD.
REQ-025 LOAD: i_fifo_pulled_data[active] (valid one cycle after pull) captured into the word shift register; byte index cleared; -> SHIFT.
REQ-026 SHIFT: each i_smi_rd -> o_smi_data = current byte and o_smi_valid=1 at next edge; byte 0 = bits[7:0] when MSB_FIRST=0, bits[WORD_W-1:WORD_W-8] when MSB_FIRST=1; index increments.
REQ-027 After the last byte (index WORD_W/8-1) is issued -> IDLE, refetch begins the following cycle.
REQ-028 Underrun: i_smi_rd while not in SHIFT -> o_smi_data=8'h00, o_smi_valid=1 at next edge, sticky bit7 set, URCNT+1 (saturating at 8'hFF).
REQ-029 EN cleared while in PULL/LOAD/SHIFT -> IDLE at next edge; remaining bytes discarded; a pull already issued is not retracted.
REQ-030 CHSEL change mid-word does not affect the current word; it applies at the next IDLE->PULL.
REQ-031 MSB_FIRST is sampled at LOAD; mid-word changes apply to the next word.
REQ-032 Simultaneous underrun and W1C write to STATUS in the same cycle: the underrun wins (bit7=1, URCNT=1).
REQ-033 Register access and streaming operate independently; simultaneous fetch and i_smi_rd are both serviced in the same cycle.

Reset
REQ-034 i_rst=1 at an edge -> FSM IDLE, CHSEL=0, CTRL=0, sticky=0, URCNT=0, o_data_out=8'h00, o_smi_data=8'h00, o_smi_valid=0, o_fifo_pull=0; an in-flight word is discarded.

Verification
REQ-035 Write CTRL=0x01, ch0 word 0x44332211 -> one pull on ch0; 4 strobes -> bytes 11,22,33,44, each with one valid pulse.
REQ-036 CTRL=0x03, CHSEL=1, ch1 word 0xA1B2C3D4 -> pull on o_fifo_pull[1] only; bytes A1,B2,C3,D4.
REQ-037 EN=1, all FIFOs empty, 3 strobes -> three 0x00 bytes; STATUS bit7=1, URCNT=3; write STATUS 0x80 -> both cleared.
REQ-038 Clear EN after 2 of 4 bytes, then set it again -> the remaining 2 bytes are dropped and the next strobes return the next FIFO word starting at byte 0.
REQ-039 Fetch at 0x00 -> 0x02; fetch at 0x1F -> 0x00; i_cs=0 -> o_data_out 0x00; write CHSEL=3 with NUM_CH=2 -> reads back 1.
REQ-040 Assert i_rst in SHIFT after byte 1 -> all outputs at reset values next cycle; no pull until EN is rewritten.

Source files
------------

// File: rtl/smi_stream_ctrl.sv
// SMI stream controller: pops words from one of several source FIFOs and hands
// them out a byte at a time on SMI read strobes, with a small register bank for control.
module smi_stream_ctrl #(
    parameter int           NUM_CH         = 2,
    parameter int           WORD_W         = 32,
    parameter logic [7:0]   MODULE_VERSION = 8'h02
) (
    input  logic                     i_sys_clk,
    input  logic                     i_rst,
    input  logic [4:0]               i_ioc,
    input  logic [7:0]               i_data_in,
    output logic [7:0]               o_data_out,
    input  logic                     i_cs,
    input  logic                     i_fetch_cmd,
    input  logic                     i_load_cmd,
    output logic [NUM_CH-1:0]        o_fifo_pull,
    input  logic [NUM_CH*WORD_W-1:0] i_fifo_pulled_data,
    input  logic [NUM_CH-1:0]        i_fifo_empty,
    input  logic                     i_smi_rd,
    output logic [7:0]               o_smi_data,
    output logic                     o_smi_valid
);

    localparam int                NBYTES   = WORD_W / 8;
    localparam int                IDX_W    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NBYTES - 1);
    localparam logic [1:0]        MAX_CH   = 2'(NUM_CH - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_PULL, ST_LOAD, ST_SHIFT} state_t;

    state_t             state_reg, state_next;
    logic [1:0]         chsel_reg;
    logic [1:0]         active_ch_reg;
    logic               en_reg;
    logic               msb_first_reg;
    logic               msb_word_reg;
    logic               sticky_reg;
    logic [7:0]         urcnt_reg;
    logic [7:0]         data_out_reg;
    logic [7:0]         smi_data_reg;
    logic               smi_valid_reg;
    logic [WORD_W-1:0]  word_reg;
    logic [IDX_W-1:0]   idx_reg;

    logic [3:0]         empty_pad;
    logic [WORD_W-1:0]  ch_word [4];
    logic [6:0]         status_low;
    logic [7:0]         rd_value;
    logic [7:0]         cur_byte;
    logic               reg_wr;
    logic               reg_rd;
    logic               w1c_clear;
    logic               underrun;
    logic               byte_take;
    logic               unused_data_bits;

    // Channel views padded out to the 2-bit CHSEL range; absent channels read as empty.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_ch
            if (gi < NUM_CH) begin : g_present
                assign empty_pad[gi] = i_fifo_empty[gi];
                assign ch_word[gi]   = i_fifo_pulled_data[gi*WORD_W +: WORD_W];
            end else begin : g_absent
                assign empty_pad[gi] = 1'b1;
                assign ch_word[gi]   = '0;
            end
        end
        for (genvar gi = 0; gi < 7; gi++) begin : g_status
            if (gi < NUM_CH) begin : g_bit
                assign status_low[gi] = i_fifo_empty[gi];
            end else begin : g_zero
                assign status_low[gi] = 1'b0;
            end
        end
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_pull
            assign o_fifo_pull[gi] = (state_reg == ST_PULL) && (active_ch_reg == 2'(gi));
        end
    endgenerate

    assign reg_wr           = i_cs & i_load_cmd;
    assign reg_rd           = i_cs & i_fetch_cmd;
    assign w1c_clear        = reg_wr && (i_ioc == 5'h03) && i_data_in[7];
    assign underrun         = i_smi_rd && (state_reg != ST_SHIFT);
    assign byte_take        = i_smi_rd && (state_reg == ST_SHIFT);
    assign cur_byte         = msb_word_reg ? word_reg[WORD_W-1 -: 8] : word_reg[7:0];
    assign unused_data_bits = ^i_data_in[6:2];

    assign o_data_out  = data_out_reg;
    assign o_smi_data  = smi_data_reg;
    assign o_smi_valid = smi_valid_reg;

    always_comb begin
        rd_value = 8'h00;
        case (i_ioc)
            5'h00:   rd_value = MODULE_VERSION;
            5'h01:   rd_value = {6'b0, chsel_reg};
            5'h02:   rd_value = {6'b0, msb_first_reg, en_reg};
            5'h03:   rd_value = {sticky_reg, status_low};
            5'h04:   rd_value = urcnt_reg;
            default: rd_value = 8'h00;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (en_reg && !empty_pad[chsel_reg]) state_next = ST_PULL;
            ST_PULL:  state_next = en_reg ? ST_LOAD : ST_IDLE;
            ST_LOAD:  state_next = en_reg ? ST_SHIFT : ST_IDLE;
            ST_SHIFT: begin
                if (!en_reg)
                    state_next = ST_IDLE;
                else if (byte_take && (idx_reg == LAST_IDX))
                    state_next = ST_IDLE;
            end
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            state_reg     <= ST_IDLE;
            chsel_reg     <= 2'd0;
            active_ch_reg <= 2'd0;
            en_reg        <= 1'b0;
            msb_first_reg <= 1'b0;
            msb_word_reg  <= 1'b0;
            sticky_reg    <= 1'b0;
            urcnt_reg     <= 8'h00;
            data_out_reg  <= 8'h00;
            smi_data_reg  <= 8'h00;
            smi_valid_reg <= 1'b0;
            word_reg      <= '0;
            idx_reg       <= '0;
        end else begin
            state_reg <= state_next;

            if (reg_rd)
                data_out_reg <= rd_value;
            else if (!i_cs)
                data_out_reg <= 8'h00;

            if (reg_wr) begin
                case (i_ioc)
                    5'h01: chsel_reg <= (i_data_in[1:0] > MAX_CH) ? MAX_CH : i_data_in[1:0];
                    5'h02: begin
                        en_reg        <= i_data_in[0];
                        msb_first_reg <= i_data_in[1];
                    end
                    default: ;
                endcase
            end

            // An underrun in the same cycle as the W1C wins and restarts the count at 1.
            if (underrun) begin
                sticky_reg <= 1'b1;
                if (w1c_clear)
                    urcnt_reg <= 8'h01;
                else if (urcnt_reg != 8'hFF)
                    urcnt_reg <= urcnt_reg + 8'h01;
            end else if (w1c_clear) begin
                sticky_reg <= 1'b0;
                urcnt_reg  <= 8'h00;
            end

            smi_valid_reg <= i_smi_rd;
            if (byte_take) begin
                smi_data_reg <= cur_byte;
                word_reg     <= msb_word_reg ? (word_reg << 8) : (word_reg >> 8);
                idx_reg      <= idx_reg + 1'b1;
            end else if (underrun) begin
                smi_data_reg <= 8'h00;
            end

            if ((state_reg == ST_IDLE) && (state_next == ST_PULL))
                active_ch_reg <= chsel_reg;

            // FIFO data is valid the cycle after the pop, which is the LOAD cycle.
            if (state_reg == ST_LOAD) begin
                word_reg     <= ch_word[active_ch_reg];
                idx_reg      <= '0;
                msb_word_reg <= msb_first_reg;
            end
        end
    end

endmodule

// File: tb/tb_smi_stream_ctrl.sv
// Bench for smi_stream_ctrl: directed scenarios plus random traffic, all checked
// every cycle against a queue-based behavioural model of the controller.
module tb_smi_stream_ctrl;

    localparam int NUM_CH = 2;
    localparam int WORD_W = 32;
    localparam int NB     = WORD_W / 8;

    logic                     clk = 1'b0;
    logic                     i_rst = 1'b1;
    logic [4:0]               i_ioc = '0;
    logic [7:0]               i_data_in = '0;
    logic [7:0]               o_data_out;
    logic                     i_cs = 1'b0;
    logic                     i_fetch_cmd = 1'b0;
    logic                     i_load_cmd = 1'b0;
    logic [NUM_CH-1:0]        o_fifo_pull;
    logic [NUM_CH*WORD_W-1:0] i_fifo_pulled_data = '0;
    logic [NUM_CH-1:0]        i_fifo_empty = '1;
    logic                     i_smi_rd = 1'b0;
    logic [7:0]               o_smi_data;
    logic                     o_smi_valid;

    always #5 clk = ~clk;

    smi_stream_ctrl #(.NUM_CH(NUM_CH), .WORD_W(WORD_W), .MODULE_VERSION(8'h02)) dut (
        .i_sys_clk          (clk),
        .i_rst              (i_rst),
        .i_ioc              (i_ioc),
        .i_data_in          (i_data_in),
        .o_data_out         (o_data_out),
        .i_cs               (i_cs),
        .i_fetch_cmd        (i_fetch_cmd),
        .i_load_cmd         (i_load_cmd),
        .o_fifo_pull        (o_fifo_pull),
        .i_fifo_pulled_data (i_fifo_pulled_data),
        .i_fifo_empty       (i_fifo_empty),
        .i_smi_rd           (i_smi_rd),
        .o_smi_data         (o_smi_data),
        .o_smi_valid        (o_smi_valid)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    bit cmp_on = 1'b0;
    int pull_cnt [NUM_CH];

    // Source FIFOs as circular buffers; pulled_word is what each FIFO presents after a pop.
    logic [31:0] fifo_mem [NUM_CH][16];
    int          fifo_rd  [NUM_CH];
    int          fifo_wr  [NUM_CH];
    logic [31:0] pulled_word [NUM_CH];

    // Model: phase 0 waiting for data, 1 pop requested, 2 word arriving, 3 bytes pending.
    int          m_phase = 0;
    int          m_active = 0;
    logic [7:0]  m_bytes [$];
    logic [1:0]  m_chsel = '0;
    logic        m_en = 1'b0;
    logic        m_msb = 1'b0;
    logic        m_sticky = 1'b0;
    int          m_urcnt = 0;
    logic [7:0]  m_dout = '0;
    logic [7:0]  m_sdata = '0;
    logic        m_svalid = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_fifo();
        for (int k = 0; k < NUM_CH; k++) begin
            i_fifo_pulled_data[k*WORD_W +: WORD_W] = pulled_word[k];
            i_fifo_empty[k] = (fifo_wr[k] == fifo_rd[k]);
        end
    endtask

    task automatic push(input int ch, input logic [31:0] w);
        fifo_mem[ch][fifo_wr[ch] % 16] = w;
        fifo_wr[ch]++;
        drive_fifo();
    endtask

    task automatic model_step();
        logic [7:0]  rv;
        logic        underrun;
        logic [31:0] w;
        int          pop_ch;
        pop_ch = (m_phase == 1) ? m_active : -1;
        if (i_rst) begin
            m_phase = 0; m_bytes.delete();
            m_chsel = '0; m_en = 0; m_msb = 0; m_sticky = 0; m_urcnt = 0;
            m_dout = '0; m_sdata = '0; m_svalid = 0;
        end else begin
            case (i_ioc)
                5'h00:   rv = 8'h02;
                5'h01:   rv = {6'b0, m_chsel};
                5'h02:   rv = {6'b0, m_msb, m_en};
                5'h03:   rv = {m_sticky, 5'b0, i_fifo_empty};
                5'h04:   rv = 8'(m_urcnt);
                default: rv = 8'h00;
            endcase
            if (i_cs && i_fetch_cmd) m_dout = rv;
            else if (!i_cs)          m_dout = 8'h00;

            underrun = i_smi_rd && (m_phase != 3);
            m_svalid = i_smi_rd;
            if (i_smi_rd) m_sdata = (m_phase == 3) ? m_bytes.pop_front() : 8'h00;

            case (m_phase)
                0: if (m_en && !i_fifo_empty[m_chsel]) begin m_phase = 1; m_active = int'(m_chsel); end
                1: m_phase = m_en ? 2 : 0;
                2: begin
                    if (m_en) begin
                        w = pulled_word[m_active];
                        m_bytes.delete();
                        for (int k = 0; k < NB; k++)
                            m_bytes.push_back(m_msb ? 8'(w >> (8*(NB-1-k))) : 8'(w >> (8*k)));
                        m_phase = 3;
                    end else m_phase = 0;
                end
                default: begin
                    if (!m_en) begin m_phase = 0; m_bytes.delete(); end
                    else if (m_bytes.size() == 0) m_phase = 0;
                end
            endcase

            if (i_cs && i_load_cmd) begin
                if (i_ioc == 5'h01) m_chsel = (i_data_in[1:0] > 2'd1) ? 2'd1 : i_data_in[1:0];
                if (i_ioc == 5'h02) begin m_en = i_data_in[0]; m_msb = i_data_in[1]; end
                if (i_ioc == 5'h03 && i_data_in[7]) begin m_sticky = 0; m_urcnt = 0; end
            end
            if (underrun) begin
                m_sticky = 1;
                if (m_urcnt < 255) m_urcnt++;
            end
        end
        if (pop_ch >= 0 && fifo_wr[pop_ch] != fifo_rd[pop_ch]) begin
            pulled_word[pop_ch] = fifo_mem[pop_ch][fifo_rd[pop_ch] % 16];
            fifo_rd[pop_ch]++;
        end
    endtask

    task automatic step(input logic cs, input logic fetch, input logic load, input logic [4:0] ioc,
                        input logic [7:0] din, input logic rd, input logic rst);
        i_cs = cs; i_fetch_cmd = fetch; i_load_cmd = load; i_ioc = ioc;
        i_data_in = din; i_smi_rd = rd; i_rst = rst;
        @(posedge clk);
        #1;
        model_step();
        drive_fifo();
        #1;
    endtask

    task automatic idle();                                     step(0, 0, 0, 5'h00, 8'h00, 0, 0); endtask
    task automatic wr(input logic [4:0] a, input logic [7:0] d); step(1, 0, 1, a, d, 0, 0);        endtask
    task automatic rdreg(input logic [4:0] a);                 step(1, 1, 0, a, 8'h00, 0, 0);     endtask
    task automatic strobe();                                   step(0, 0, 0, 5'h00, 8'h00, 1, 0); endtask

    task automatic expect_byte(input string name, input logic [7:0] b);
        strobe();
        chk({name, "_valid"}, 32'(o_smi_valid), 32'd1);
        chk({name, "_data"}, 32'(o_smi_data), 32'(b));
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("cyc_dout", 32'(o_data_out), 32'(m_dout));
            chk("cyc_smi_valid", 32'(o_smi_valid), 32'(m_svalid));
            chk("cyc_smi_data", 32'(o_smi_data), 32'(m_sdata));
            chk("cyc_fifo_pull", 32'(o_fifo_pull), (m_phase == 1) ? (32'd1 << m_active) : 32'd0);
            for (int k = 0; k < NUM_CH; k++) pull_cnt[k] += int'(o_fifo_pull[k]);
            if (o_smi_valid === 1'b1) $display("smi byte %02h", o_smi_data);
        end
    end

    initial begin
        int          pc_before;
        logic [7:0]  din;
        logic [4:0]  ioc;
        for (int k = 0; k < NUM_CH; k++) begin
            fifo_rd[k] = 0; fifo_wr[k] = 0; pulled_word[k] = '0; pull_cnt[k] = 0;
        end
        drive_fifo();
        step(0, 0, 0, 5'h00, 8'h00, 0, 1);
        step(0, 0, 0, 5'h00, 8'h00, 0, 1);
        cmp_on = 1'b1;
        chk("rst_dout", 32'(o_data_out), 32'h00);
        chk("rst_valid", 32'(o_smi_valid), 32'h0);
        chk("rst_pull", 32'(o_fifo_pull), 32'h0);

        // LSB-first word on channel 0
        push(0, 32'h44332211);
        wr(5'h02, 8'h01);
        idle();
        chk("ch0_pull", 32'(o_fifo_pull), 32'h1);
        idle(); idle();
        expect_byte("lsb_b0", 8'h11);
        expect_byte("lsb_b1", 8'h22);
        expect_byte("lsb_b2", 8'h33);
        expect_byte("lsb_b3", 8'h44);
        idle();
        chk("lsb_done_valid", 32'(o_smi_valid), 32'h0);
        chk("pulls_ch0_a", 32'(pull_cnt[0]), 32'd1);
        wr(5'h02, 8'h00);

        // MSB-first word on channel 1
        push(1, 32'hA1B2C3D4);
        wr(5'h01, 8'h01);
        wr(5'h02, 8'h03);
        idle();
        chk("ch1_pull", 32'(o_fifo_pull), 32'h2);
        idle(); idle();
        expect_byte("msb_b0", 8'hA1);
        expect_byte("msb_b1", 8'hB2);
        expect_byte("msb_b2", 8'hC3);
        expect_byte("msb_b3", 8'hD4);
        chk("pulls_ch1", 32'(pull_cnt[1]), 32'd1);
        chk("pulls_ch0_b", 32'(pull_cnt[0]), 32'd1);
        wr(5'h02, 8'h00);
        wr(5'h01, 8'h00);

        // Underruns with every FIFO empty, W1C clear, and underrun beating W1C
        wr(5'h02, 8'h01);
        expect_byte("ur0", 8'h00);
        expect_byte("ur1", 8'h00);
        expect_byte("ur2", 8'h00);
        rdreg(5'h03);
        chk("ur_status", 32'(o_data_out), 32'h83);
        rdreg(5'h04);
        chk("ur_count", 32'(o_data_out), 32'd3);
        chk("model_urcnt", 32'(m_urcnt), 32'd3);
        wr(5'h03, 8'h80);
        rdreg(5'h03);
        chk("w1c_status", 32'(o_data_out), 32'h03);
        rdreg(5'h04);
        chk("w1c_count", 32'(o_data_out), 32'd0);
        step(1, 0, 1, 5'h03, 8'h80, 1, 0);
        rdreg(5'h04);
        chk("race_count", 32'(o_data_out), 32'd1);
        rdreg(5'h03);
        chk("race_status", 32'(o_data_out), 32'h83);
        wr(5'h03, 8'h80);
        wr(5'h02, 8'h00);

        // Disable mid-word drops the rest; next word starts at byte 0
        push(0, 32'h0D0C0B0A);
        push(0, 32'h1D1C1B1A);
        wr(5'h02, 8'h01);
        idle(); idle(); idle();
        expect_byte("drop_b0", 8'h0A);
        expect_byte("drop_b1", 8'h0B);
        wr(5'h02, 8'h00);
        idle();
        wr(5'h02, 8'h01);
        idle(); idle(); idle();
        expect_byte("next_b0", 8'h1A);
        expect_byte("next_b1", 8'h1B);
        expect_byte("next_b2", 8'h1C);
        expect_byte("next_b3", 8'h1D);
        chk("pulls_ch0_c", 32'(pull_cnt[0]), 32'd3);
        wr(5'h02, 8'h00);

        // Register read path
        rdreg(5'h00);
        chk("rd_version", 32'(o_data_out), 32'h02);
        step(1, 0, 0, 5'h00, 8'h00, 0, 0);
        chk("rd_hold", 32'(o_data_out), 32'h02);
        rdreg(5'h1F);
        chk("rd_unmapped", 32'(o_data_out), 32'h00);
        rdreg(5'h00);
        idle();
        chk("rd_cs_low", 32'(o_data_out), 32'h00);
        wr(5'h01, 8'h03);
        rdreg(5'h01);
        chk("chsel_clamp", 32'(o_data_out), 32'h01);
        wr(5'h01, 8'h00);

        // Reset in the middle of a word
        push(0, 32'h55667788);
        wr(5'h02, 8'h01);
        idle(); idle(); idle();
        expect_byte("pre_rst_b0", 8'h88);
        step(0, 0, 0, 5'h00, 8'h00, 0, 1);
        chk("mid_rst_dout", 32'(o_data_out), 32'h00);
        chk("mid_rst_valid", 32'(o_smi_valid), 32'h0);
        chk("mid_rst_data", 32'(o_smi_data), 32'h00);
        chk("mid_rst_pull", 32'(o_fifo_pull), 32'h0);
        pc_before = pull_cnt[0];
        push(0, 32'h99AABBCC);
        idle(); idle(); idle(); idle();
        chk("no_pull_after_rst", 32'(pull_cnt[0]), 32'(pc_before));
        wr(5'h02, 8'h01);
        idle(); idle();
        chk("pull_after_en", 32'(pull_cnt[0]), 32'(pc_before + 1));
        idle();
        expect_byte("post_rst_b0", 8'hCC);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                int ch;
                ch = int'($urandom_range(0, NUM_CH - 1));
                if (fifo_wr[ch] - fifo_rd[ch] < 12) push(ch, $urandom);
            end
            ioc = ($urandom_range(0, 19) == 0) ? 5'h1F : 5'($urandom_range(0, 5));
            din = 8'($urandom);
            if (ioc == 5'h02 && $urandom_range(0, 3) != 0) din[0] = 1'b1;
            step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 99) < 8,
                 ioc, din, $urandom_range(0, 2) == 0, $urandom_range(0, 499) == 0);
        end

        cmp_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
